// File: rtl/flop_pipe_pkg.sv
// flop_pipe_pkg: shared parameter limits and occupancy width helper for flop_pipe_vr
package flop_pipe_pkg;
  localparam int MAX_WIDTH = 1024;
  localparam int MAX_DEPTH = 64;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/flop_pipe_stage.sv
// flop_pipe_stage: one valid/data register stage; up_valid/up_data in, dn_ready in, vld/dat/rdy out
module flop_pipe_stage
  import flop_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic             rdy
);
  logic             vld_d, vld_q;
  logic [WIDTH-1:0] dat_d, dat_q;
  always_comb begin
    rdy   = !vld_q || dn_ready;
    vld_d = rdy ? up_valid : vld_q;
    dat_d = (rdy && up_valid) ? up_data : dat_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= RESET_DATA;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
  assign vld = vld_q;
  assign dat = dat_q;
endmodule

// File: rtl/flop_pipe_vr.sv
// flop_pipe_vr: DEPTH x WIDTH valid/ready retiming pipe with bubble collapse; in_valid/in_data/in_ready, out_valid/out_data/out_ready, occupancy
module flop_pipe_vr
  import flop_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 3,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);
  localparam int OW = occ_w(DEPTH);
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("flop_pipe_vr: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("flop_pipe_vr: DEPTH %0d outside 1..%0d", DEPTH, MAX_DEPTH);
  end
  logic [DEPTH:0]   v;
  logic [WIDTH-1:0] d [DEPTH+1];
  logic [DEPTH-1:0] r, dn;
  logic [OW-1:0]    occ_d, occ_q;
  logic             in_acc, out_acc;
  assign v[0] = in_valid;
  assign d[0] = in_data;
  always_comb begin
    dn[DEPTH-1] = out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) dn[i] = dn[i+1] || !v[i+2];
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    flop_pipe_stage #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (v[i]),
      .up_data  (d[i]),
      .dn_ready (dn[i]),
      .vld      (v[i+1]),
      .dat      (d[i+1]),
      .rdy      (r[i])
    );
  end
  always_comb begin
    in_ready = |r;
    in_acc   = in_valid && in_ready;
    out_acc  = v[DEPTH] && out_ready;
    occ_d    = (in_acc == out_acc) ? occ_q : in_acc ? occ_q + OW'(1) : occ_q - OW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end
  assign out_valid = v[DEPTH];
  assign out_data  = d[DEPTH];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_flop_pipe_vr.sv
// tb_flop_pipe_vr: scoreboard bench for flop_pipe_vr plus a WIDTH=1/DEPTH=1 corner instance
module tb_flop_pipe_vr;
  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0, out_ready = 0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic       c_rst = 1, c_in_valid = 0, c_in_data = 0, c_out_ready = 1;
  logic       c_in_ready, c_out_valid, c_out_data;
  logic [0:0] c_occ;
  int         checks = 0, errors = 0;
  int         exp_occ = 0;
  logic [7:0] q [$];
  logic       hold = 0;
  logic [7:0] held = '0;

  always #5 clk = ~clk;

  flop_pipe_vr #(.WIDTH(8), .DEPTH(3), .RESET_DATA(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .occupancy(occupancy)
  );

  flop_pipe_vr #(.WIDTH(1), .DEPTH(1), .RESET_DATA(1'b1)) dut_c (
    .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready), .occupancy(c_occ)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] dv, input logic rd, input logic rs = 1'b0);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = dv;
    out_ready = rd;
    rst       = rs;
    #2;
    if (!rst && in_valid && in_ready) q.push_back(in_data);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_occ = 0;
      hold = 0;
    end else begin
      chk("occupancy", occupancy, exp_occ);
      chk("in_ready", in_ready, (exp_occ < 3) || out_ready);
      if (hold) chk("out_stable", out_data, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", out_data, 32'hDEAD);
        else chk("out_data", out_data, q.pop_front());
      end
      hold = out_valid && !out_ready;
      held = out_data;
      exp_occ += int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  initial begin
    @(posedge clk); #1 c_rst = 1;
    @(posedge clk); #1 c_rst = 0;
    #2;
    chk("c_rst_data", c_out_data, 1);
    chk("c_rst_valid", c_out_valid, 0);
    chk("c_rst_occ", c_occ, 0);
    chk("c_rst_ready", c_in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      c_in_valid = 1;
      c_in_data  = k[0];
      #2;
      chk("c_in_ready", c_in_ready, 1);
      if (k > 0) begin
        chk("c_valid", c_out_valid, 1);
        chk("c_data", c_out_data, (k - 1) % 2);
        chk("c_occ", c_occ, 1);
      end
    end
    @(posedge clk); #1 c_in_valid = 0;
    #2 chk("c_last", c_out_data, 1);
    @(posedge clk); #3;
    chk("c_empty_valid", c_out_valid, 0);
    chk("c_empty_occ", c_occ, 0);

    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);

    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    chk("lat_not_yet", out_valid, 0);
    step(1'b1, 8'h44, 1'b1);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 8'h11);
    drain();

    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    step(1'b1, 8'hA4, 1'b0);
    chk("stall_ready", in_ready, 0);
    chk("stall_occ", occupancy, 3);
    chk("stall_data", out_data, 8'hA1);
    step(1'b1, 8'hA4, 1'b0);
    step(1'b1, 8'hA4, 1'b1);
    drain();

    step(1'b1, 8'h01, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("bubble_occ", occupancy, 2);
    chk("bubble_ready", in_ready, 1);
    chk("bubble_out", out_valid, 1);
    step(1'b1, 8'h03, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("bubble_full", occupancy, 3);
    drain();

    step(1'b1, 8'h61, 1'b0);
    step(1'b1, 8'h62, 1'b0);
    step(1'b1, 8'h63, 1'b0);
    step(1'b1, 8'h5C, 1'b1);
    chk("simul_ready", in_ready, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("simul_occ", occupancy, 3);
    drain();

    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h30, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_ready", in_ready, 1);
    drain();

    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 59) == 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
